// File: rtl/div_iter_if.sv
// Pipeline-to-divider handshake: operation request/abort toward the divider,
// stall request, ready pulse and {remainder, quotient} result back.
interface div_iter_if #(
   parameter int DATA_W = 32
);
   logic                  start;
   logic                  signed_div;
   logic [DATA_W-1:0]     opdata1;
   logic [DATA_W-1:0]     opdata2;
   logic                  annul;
   logic                  stall_div;
   logic                  ready;
   logic [2*DATA_W-1:0]   result;

   modport master (
      output start, signed_div, opdata1, opdata2, annul,
      input  stall_div, ready, result
   );

   modport slave (
      input  start, signed_div, opdata1, opdata2, annul,
      output stall_div, ready, result
   );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute stage.
// Stalls the pipeline while busy and returns {hi = remainder, lo = quotient}.
module div_iter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic      clk,
   input  logic      resetn,
   div_iter_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
      return ~v + {{(DATA_W-1){1'b0}}, 1'b1};
   endfunction

   // Signed operands are reduced to magnitudes; 0x80..0 wraps onto itself.
   function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                   input logic isSigned);
      if (isSigned && v[DATA_W-1]) begin
         return negate(v);
      end else begin
         return v;
      end
   endfunction

   logic [1:0]          stateR;
   logic [1:0]          nextStateS;
   logic [CNT_W-1:0]    cntR;
   logic [DATA_W-1:0]   divisorR;
   logic [DATA_W-1:0]   remR;
   logic [DATA_W-1:0]   quoR;
   logic                quoSignR;
   logic                remSignR;
   logic [2*DATA_W-1:0] resultR;

   logic                stallS;
   logic                readyS;
   logic                launchS;
   logic                divZeroS;
   logic                lastStepS;
   logic [DATA_W:0]     shiftedS;
   logic [DATA_W:0]     trialS;
   logic                negativeS;
   logic [DATA_W-1:0]   stepRemS;
   logic [DATA_W-1:0]   stepQuoS;
   logic [2*DATA_W-1:0] finalResultS;

   assign launchS   = bus.start & ~bus.annul;
   assign divZeroS  = (bus.opdata2 == {DATA_W{1'b0}});
   assign lastStepS = (cntR == CNT_W'(DATA_W - 1));

   // One restoring step: the dividend is held in quoR and shifts into remR as quotient bits fill in.
   always_comb begin
      shiftedS     = {remR, quoR[DATA_W-1]};
      trialS       = shiftedS - {1'b0, divisorR};
      negativeS    = trialS[DATA_W];
      stepRemS     = negativeS ? shiftedS[DATA_W-1:0] : trialS[DATA_W-1:0];
      stepQuoS     = {quoR[DATA_W-2:0], ~negativeS};
      finalResultS = {(remSignR ? negate(stepRemS) : stepRemS),
                      (quoSignR ? negate(stepQuoS) : stepQuoS)};
   end

   // Stall/ready outputs and next-state selection; annul wins over everything.
   always_comb begin
      stallS     = 1'b0;
      readyS     = 1'b0;
      nextStateS = IDLE;
      case (stateR)
         IDLE: begin
            stallS = launchS;
            if (launchS) begin
               nextStateS = divZeroS ? DONE : BUSY;
            end else begin
               nextStateS = IDLE;
            end
         end
         BUSY: begin
            stallS = ~bus.annul;
            if (bus.annul) begin
               nextStateS = IDLE;
            end else if (lastStepS) begin
               nextStateS = DONE;
            end else begin
               nextStateS = BUSY;
            end
         end
         DONE: begin
            readyS     = ~bus.annul;
            nextStateS = IDLE;
         end
         default: begin
            nextStateS = IDLE;
         end
      endcase
   end

   // State, operand latches, iteration datapath and result register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         stateR   <= IDLE;
         cntR     <= {CNT_W{1'b0}};
         divisorR <= {DATA_W{1'b0}};
         remR     <= {DATA_W{1'b0}};
         quoR     <= {DATA_W{1'b0}};
         quoSignR <= 1'b0;
         remSignR <= 1'b0;
         resultR  <= {(2*DATA_W){1'b0}};
      end else begin
         stateR <= nextStateS;
         case (stateR)
            IDLE: begin
               if (launchS && divZeroS) begin
                  resultR <= {(2*DATA_W){1'b0}};
               end else if (launchS) begin
                  remR     <= {DATA_W{1'b0}};
                  quoR     <= magnitude(bus.opdata1, bus.signed_div);
                  divisorR <= magnitude(bus.opdata2, bus.signed_div);
                  quoSignR <= bus.signed_div & (bus.opdata1[DATA_W-1] ^ bus.opdata2[DATA_W-1]);
                  remSignR <= bus.signed_div & bus.opdata1[DATA_W-1];
                  cntR     <= {CNT_W{1'b0}};
               end else begin
                  cntR <= cntR;
               end
            end
            BUSY: begin
               if (!bus.annul) begin
                  remR <= stepRemS;
                  quoR <= stepQuoS;
                  cntR <= cntR + {{(CNT_W-1){1'b0}}, 1'b1};
                  if (lastStepS) begin
                     resultR <= finalResultS;
                  end else begin
                     resultR <= resultR;
                  end
               end else begin
                  cntR <= cntR;
               end
            end
            default: begin
               cntR <= cntR;
            end
         endcase
      end
   end

   assign bus.stall_div = stallS;
   assign bus.ready     = readyS;
   assign bus.result    = resultR;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: directed MIPS DIV/DIVU cases plus random
// operations against a plain-arithmetic reference model.
module tb_div_iter;

   localparam int DATA_W = 32;

   logic        clk;
   logic        resetn;
   logic [63:0] lastRes;
   int          checkCnt;
   int          errCnt;

   div_iter_if #(.DATA_W(DATA_W)) bus ();

   div_iter #(.DATA_W(DATA_W), .CNT_W(6)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errCnt++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // MIPS semantics: truncating division, remainder takes the dividend's sign, x/0 gives 0.
   function automatic logic [63:0] refDiv(input logic [31:0] a, input logic [31:0] b, input logic sgn);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sgn) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Issue one operation at posedge+1; annulAt/rstAt (-1 = never) abort it in that cycle.
   task automatic runOp(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        input int annulAt, input int rstAt, input bit trail);
      logic [63:0] expRes;
      int          doneCyc;
      bit          aborted;
      expRes  = refDiv(a, b, sgn);
      doneCyc = (b == 32'd0) ? 1 : DATA_W + 1;
      aborted = 1'b0;
      bus.start      = 1'b1;
      bus.signed_div = sgn;
      bus.opdata1    = a;
      bus.opdata2    = b;
      for (int c = 0; c <= doneCyc && !aborted; c++) begin
         if (c == annulAt) bus.annul = 1'b1;
         if (c == rstAt) resetn = 1'b0;
         @(negedge clk);
         if (c == annulAt) begin
            checkVal("stall_annul", 64'(bus.stall_div), 64'd0);
            checkVal("ready_annul", 64'(bus.ready), 64'd0);
         end else begin
            checkVal("stall", 64'(bus.stall_div), 64'(c < doneCyc));
            checkVal("ready", 64'(bus.ready), 64'(c == doneCyc));
         end
         if (c == doneCyc) begin
            checkVal("result", bus.result, expRes);
            lastRes = expRes;
         end
         if (c == annulAt || c == rstAt) aborted = 1'b1;
         if (c == rstAt) lastRes = 64'd0;
         @(posedge clk);
         #1;
         bus.annul = 1'b0;
         resetn    = 1'b1;
         if (aborted || c + 1 >= doneCyc) begin
            bus.start = 1'b0;
         end else begin
            bus.opdata1    = $urandom;
            bus.opdata2    = $urandom;
            bus.signed_div = 1'($urandom_range(0, 1));
         end
      end
      if (trail) begin
         @(negedge clk);
         checkVal("idle_stall", 64'(bus.stall_div), 64'd0);
         checkVal("idle_ready", 64'(bus.ready), 64'd0);
         checkVal("held_result", bus.result, lastRes);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rs;
      int          ann;
      checkCnt       = 0;
      errCnt         = 0;
      lastRes        = 64'd0;
      resetn         = 1'b0;
      bus.start      = 1'b0;
      bus.signed_div = 1'b0;
      bus.opdata1    = 32'd0;
      bus.opdata2    = 32'd0;
      bus.annul      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("rst_result", bus.result, 64'd0);
      checkVal("rst_ready", 64'(bus.ready), 64'd0);
      checkVal("rst_stall", 64'(bus.stall_div), 64'd0);
      @(posedge clk);
      #1;
      resetn = 1'b1;

      runOp(32'd100, 32'd7, 1'b0, -1, -1, 1'b1);
      checkVal("divu_100_7", bus.result, 64'h00000002_0000000E);
      runOp(32'hFFFFFFF9, 32'd2, 1'b1, -1, -1, 1'b1);
      checkVal("div_m7_2", bus.result, 64'hFFFFFFFF_FFFFFFFD);
      runOp(32'd7, 32'hFFFFFFFE, 1'b1, -1, -1, 1'b1);
      checkVal("div_7_m2", bus.result, 64'h00000001_FFFFFFFD);
      runOp(32'd100, 32'd7, 1'b0, -1, -1, 1'b1);
      runOp(32'd123, 32'd0, 1'b1, -1, -1, 1'b1);
      checkVal("div_by_zero", bus.result, 64'd0);

      runOp(32'd100, 32'd7, 1'b0, -1, -1, 1'b1);
      runOp(32'd5000, 32'd5, 1'b0, 10, -1, 1'b1);
      checkVal("annul_busy_hold", bus.result, 64'h00000002_0000000E);
      runOp(32'd50, 32'd5, 1'b0, 0, -1, 1'b1);
      runOp(32'd1000, 32'd3, 1'b0, DATA_W + 1, -1, 1'b1);
      runOp(32'hDEADBEEF, 32'd9, 1'b1, -1, 20, 1'b1);
      checkVal("reset_mid_op", bus.result, 64'd0);

      runOp(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, -1, 1'b0);
      checkVal("div_overflow", bus.result, 64'h00000000_80000000);
      runOp(32'hFFFFFFFF, 32'h00000010, 1'b0, -1, -1, 1'b1);
      checkVal("back_to_back", bus.result, 64'h0000000F_0FFFFFFF);

      for (int i = 0; i < 24; i++) begin
         ra = $urandom;
         case (i % 4)
            0: rb = (i % 8 == 0) ? 32'd0 : 32'($urandom_range(1, 255));
            1: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 255));
            default: rb = $urandom;
         endcase
         rs  = 1'($urandom_range(0, 1));
         ann = (i % 5 == 4) ? int'($urandom_range(1, DATA_W + 1)) : -1;
         runOp(ra, rb, rs, ann, -1, 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
      $finish;
   end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle iterative radix-2 divider for MIPS DIV/DIVU in the execute stage.
- Produces stall_div, which the hazard unit consumes as stall_divE to freeze F/D/E while a division is in progress.
- Returns a 64-bit {remainder, quotient} that the E stage routes to the HI/LO write path.
- Supports abort on exception flush.

Parameters:
- DATA_W, 32, operand width; result width is 2*DATA_W.
- CNT_W, 6, iteration counter width; must hold values 0..DATA_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  synchronous, active-low reset.
- start  input  1  DIV/DIVU decoded in E; held high by the pipeline while stalled.
- signed_div  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1  input  DATA_W  dividend (rs value after forwarding).
- opdata2  input  DATA_W  divisor (rt value after forwarding).
- annul  input  1  exception flush; aborts any operation.
- stall_div  output  1  request to stall F/D/E (goes to hazard stall_divE).
- ready  output  1  one-cycle pulse: result valid.
- result  output  2*DATA_W  {hi = remainder, lo = quotient}.

Behaviour:
- Reset (resetn=0 at a clock edge): state=IDLE, counter=0, ready=0, result=0. Reset overrides all other inputs, including mid-operation.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall_div = start & ~annul, combinational, so it is high in the same cycle start is first seen.
  - If start & ~annul & opdata2==0: latch nothing; next state is DONE with result=0 (divide-by-zero policy).
  - Else if start & ~annul: latch |opdata1| and |opdata2| (absolute values only when signed_div=1). Also latch the quotient sign (sign1 ^ sign2) and the remainder sign (sign1). Clear the partial remainder and set counter=0. Next state BUSY.
- BUSY:
  - stall_div=1.
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor from rem. If the result is non-negative, keep it and set the quotient LSB to 1.
  - counter increments each cycle. After the step with counter==DATA_W-1, next state is DONE.
  - start, opdata1/2 and signed_div are ignored while BUSY; operands stay latched.
- DONE:
  - stall_div=0, ready=1.
  - result is registered on entry to DONE. For signed ops, negate the quotient if the quotient sign is 1 and negate the remainder if the dividend sign is 1.
  - Next state is IDLE unconditionally, so the pipeline advances on this edge and the next E instruction may issue a new start the following cycle.
- Latency: start seen in cycle 0 → BUSY in cycles 1..32 → DONE in cycle 33. stall_div is high in cycles 0..32. Divide-by-zero: DONE in cycle 1, stall_div high in cycle 0 only.
- annul:
  - Has priority over start in IDLE; no operation begins and stall_div=0.
  - In BUSY or DONE: forces stall_div=0 and ready=0 combinationally; next state IDLE. result keeps its previous value.
- result holds its value between operations; only DONE entry updates it.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. The natural wrap from magnitude arithmetic gives this; no trap.
- Arithmetic: magnitude datapath is DATA_W+1 bits for the trial subtract. Negation is two's complement modulo 2^DATA_W.

Test Plan:
- Unsigned: DIVU 100 / 7 → stall_div high in cycles 0..32, ready pulse in cycle 33, result = {0x00000002, 0x0000000E}; in cycle 34 ready=0 and state is IDLE.
- Signed: DIV 0xFFFFFFF9 (−7) / 2 → result = {0xFFFFFFFF, 0xFFFFFFFD}. Also 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero: DIV 123 / 0 → stall_div high in cycle 0 only, ready in cycle 1, result = 0.
- Abort and reset: assert annul in cycle 10 of BUSY → stall_div=0 that cycle, IDLE next cycle, no ready pulse, result unchanged. Separately, resetn=0 in cycle 20 → IDLE, result=0.
- Overflow and back-to-back: DIV 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}. Then keep start high in the cycle after DONE with DIVU 0xFFFFFFFF / 0x10 → new op begins, result {0xF, 0x0FFFFFFF} 33 cycles later.
